// File: rtl/sync_fifo_if.sv
// Handshake bundle between a same-clock producer/consumer and sync_fifo.
// master = pipeline side, slave = FIFO side.
interface sync_fifo_if #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_ENTRIES = 8
);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  logic               flush;
  logic               write_en;
  logic [WIDTH-1:0]   write_data;
  logic               full;
  logic               almost_full;
  logic               read_en;
  logic [WIDTH-1:0]   read_data;
  logic               empty;
  logic               almost_empty;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               underflow;

  modport master (
    output flush, write_en, write_data, read_en,
    input  full, almost_full, read_data, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, write_en, write_data, read_en,
    output full, almost_full, read_data, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost flags and flush.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo #(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned NUM_ENTRIES        = 8,
  parameter int unsigned ALMOST_FULL_LEVEL  = NUM_ENTRIES - 1,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
  input logic        clk,
  input logic        reset,
  sync_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  logic [WIDTH-1:0] mem [NUM_ENTRIES];
  logic [PTR_W-1:0] write_ptr;
  logic [PTR_W-1:0] read_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             full_q;
  logic             empty_q;
  logic             almost_full_q;
  logic             almost_empty_q;
  logic             write_accept;
  logic             read_accept;

  // Acceptance uses registered flags only; flush discards both requests.
  assign write_accept = bus.write_en && !full_q  && !bus.flush;
  assign read_accept  = bus.read_en  && !empty_q && !bus.flush;

  always_comb begin
    count_next = count_q;
    if (bus.flush) begin
      count_next = '0;
    end else if (write_accept && !read_accept) begin
      count_next = count_q + CNT_W'(1);
    end else if (read_accept && !write_accept) begin
      count_next = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap explicitly at NUM_ENTRIES-1 so any depth works.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
    end else if (bus.flush) begin
      write_ptr <= '0;
      read_ptr  <= '0;
    end else begin
      if (write_accept) begin
        write_ptr <= (write_ptr == PTR_W'(NUM_ENTRIES - 1)) ? '0 : write_ptr + PTR_W'(1);
      end
      if (read_accept) begin
        read_ptr <= (read_ptr == PTR_W'(NUM_ENTRIES - 1)) ? '0 : read_ptr + PTR_W'(1);
      end
    end
  end

  // Count and flags registered together so flags track the count exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      count_q        <= count_next;
      full_q         <= (count_next == CNT_W'(NUM_ENTRIES));
      empty_q        <= (count_next == '0);
      almost_full_q  <= (count_next >= CNT_W'(ALMOST_FULL_LEVEL));
      almost_empty_q <= (count_next <= CNT_W'(ALMOST_EMPTY_LEVEL));
    end
  end

  // Storage left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (write_accept) begin
      mem[write_ptr] <= bus.write_data;
    end
  end

  assign bus.read_data    = mem[read_ptr];
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write_en && full_q) overflow_q  <= 1'b1;
      if (bus.read_en && empty_q) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at depth 5: vector table plus wrap, simultaneous
// access and async-reset sequences checked against a small queue model.
module tb_sync_fifo;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct {
    bit       fl;
    bit       we;
    bit [7:0] wd;
    bit       re;
    int       cnt;
    bit       full;
    bit       af;
    bit       empty;
    bit       ae;
    bit       chk_rd;
    bit [7:0] rd;
    bit       ovf;
    bit       unf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  bit [7:0] model[$];

  sync_fifo_if #(.WIDTH(8), .NUM_ENTRIES(5)) bus ();
  sync_fifo #(.WIDTH(8), .NUM_ENTRIES(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit fl, bit we, bit [7:0] wd, bit re, int cnt, bit chk_rd,
                              bit [7:0] rd, bit ovf, bit unf);
    vec_t v;
    v.fl = fl; v.we = we; v.wd = wd; v.re = re; v.cnt = cnt;
    v.full = (cnt == 5); v.af = (cnt >= 4); v.empty = (cnt == 0); v.ae = (cnt <= 1);
    v.chk_rd = chk_rd; v.rd = rd; v.ovf = ovf & ERR; v.unf = unf & ERR;
    return v;
  endfunction

  task automatic drive(input bit fl, input bit we, input bit [7:0] wd, input bit re);
    bus.flush = fl; bus.write_en = we; bus.write_data = wd; bus.read_en = re;
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.write_en = 1'b0; bus.read_en = 1'b0;
  endtask

  // Model step: flush clears, else read pops / write pushes by occupancy.
  task automatic model_cycle(input string name, input bit fl, input bit we, input bit [7:0] wd,
                             input bit re);
    bit wa, ra;
    drive(fl, we, wd, re);
    if (fl) begin
      model.delete();
    end else begin
      wa = we && (model.size() < 5);
      ra = re && (model.size() > 0);
      if (ra) void'(model.pop_front());
      if (wa) model.push_back(wd);
    end
    chk({name, " count"}, int'(bus.count), model.size());
    if (model.size() > 0) chk({name, " read_data"}, int'(bus.read_data), int'(model[0]));
  endtask

  initial begin
    bus.flush = 1'b0; bus.write_en = 1'b0; bus.write_data = '0; bus.read_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset count", int'(bus.count), 0);
    chk("reset empty", int'(bus.empty), 1);
    chk("reset full", int'(bus.full), 0);
    chk("reset almost_empty", int'(bus.almost_empty), 1);
    chk("reset almost_full", int'(bus.almost_full), 0);
    chk("reset overflow", int'(bus.overflow), 0);
    chk("reset underflow", int'(bus.underflow), 0);

    //              fl we wd     re cnt chk rd    ovf unf
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 2, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 3, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 4, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 8'h55, 0, 5, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 8'h66, 0, 5, 1, 8'h11, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 4, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 1, 8'h33, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2, 1, 8'h44, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h55, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 1, 8'hAA, 1, 1, 1, 8'hAA, 1, 1));
    vecs.push_back(mk(0, 1, 8'hBB, 1, 1, 1, 8'hBB, 1, 1));
    vecs.push_back(mk(0, 1, 8'hCC, 0, 2, 1, 8'hBB, 1, 1));
    vecs.push_back(mk(0, 1, 8'hDD, 0, 3, 1, 8'hBB, 1, 1));
    vecs.push_back(mk(0, 1, 8'hEE, 0, 4, 1, 8'hBB, 1, 1));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 5, 1, 8'hBB, 1, 1));
    vecs.push_back(mk(0, 1, 8'h01, 1, 4, 1, 8'hCC, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 1, 8'hDD, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2, 1, 8'hEE, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hFF, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 1, 8'h10, 0, 1, 1, 8'h10, 1, 1));
    vecs.push_back(mk(0, 1, 8'h20, 0, 2, 1, 8'h10, 1, 1));
    vecs.push_back(mk(0, 1, 8'h30, 0, 3, 1, 8'h10, 1, 1));
    vecs.push_back(mk(1, 1, 8'h99, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h77, 0, 1, 1, 8'h77, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].fl, vecs[i].we, vecs[i].wd, vecs[i].re);
      chk({tag, " count"}, int'(bus.count), vecs[i].cnt);
      chk({tag, " full"}, int'(bus.full), int'(vecs[i].full));
      chk({tag, " almost_full"}, int'(bus.almost_full), int'(vecs[i].af));
      chk({tag, " empty"}, int'(bus.empty), int'(vecs[i].empty));
      chk({tag, " almost_empty"}, int'(bus.almost_empty), int'(vecs[i].ae));
      chk({tag, " overflow"}, int'(bus.overflow), int'(vecs[i].ovf));
      chk({tag, " underflow"}, int'(bus.underflow), int'(vecs[i].unf));
      if (vecs[i].chk_rd) chk({tag, " read_data"}, int'(bus.read_data), int'(vecs[i].rd));
    end

    // Wrap: hold occupancy at 2 while 12 words stream through.
    model.delete();
    model_cycle("wrap fill0", 0, 1, 8'hA0, 0);
    model_cycle("wrap fill1", 0, 1, 8'hA1, 0);
    for (int i = 0; i < 12; i++) begin
      model_cycle($sformatf("wrap%0d", i), 0, 1, 8'(8'hB0 + i), 1);
      chk($sformatf("wrap%0d count fixed", i), int'(bus.count), 2);
    end

    // Simultaneous read/write at count 3 for 10 cycles.
    model_cycle("sim fill", 0, 1, 8'hC0, 0);
    for (int i = 0; i < 10; i++) begin
      model_cycle($sformatf("sim3_%0d", i), 0, 1, 8'(8'hD0 + i), 1);
      chk($sformatf("sim3_%0d count fixed", i), int'(bus.count), 3);
    end

    // Drain through the model, then check order of remaining words.
    while (model.size() > 0) model_cycle("drain", 0, 0, 8'h00, 1);
    chk("drain empty", int'(bus.empty), 1);

    // Async reset between clock edges clears state with no clock.
    model_cycle("pre-reset w0", 0, 1, 8'h5A, 0);
    model_cycle("pre-reset w1", 0, 1, 8'h5B, 0);
    reset = 1'b1;
    #1;
    chk("async reset count", int'(bus.count), 0);
    chk("async reset empty", int'(bus.empty), 1);
    chk("async reset almost_empty", int'(bus.almost_empty), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    model.delete();
    model_cycle("post-reset w", 0, 1, 8'h3C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
